// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: requester ownership encoding and SRAM timing.
package sram_arbiter_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int SRAM_RD_LATENCY = 1;

    function automatic logic [3:0] wenFor(input logic isWrite, input logic [3:0] strb);
        return isWrite ? strb : 4'b0000;
    endfunction

endpackage

// File: rtl/sram_arbiter_dfflr.sv
// Load-enabled flop with asynchronous active-low clear, used for all arbiter state.
module sram_arbiter_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          lden_i,
    input  logic [DW-1:0] dnxt_i,
    output logic [DW-1:0] qout_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            qout_o <= '0;
        end else if (lden_i) begin
            qout_o <= dnxt_i;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous SRAM; data wins unless
// an instruction fetch has already waited through STARVE_MAX consecutive data grants.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [3:0]    data_wstrb,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,

    output logic          sram_en,
    output logic [3:0]    sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic          instGrant;
    logic          dataGrant;
    logic          anyGrant;
    logic [CW-1:0] starveCnt_d;
    logic [CW-1:0] starveCnt_q;
    owner_e        respOwner_d;
    logic          respOwner_q;
    logic          respVld_q;
    logic          respWr_q;

    // Grants are qualified by reset so nothing reaches the SRAM while reset is held.
    always_comb begin
        dataGrant = 1'b0;
        instGrant = 1'b0;
        if (reset) begin
            dataGrant = data_req && !(inst_req && (starveCnt_q == CNT_MAX));
            instGrant = inst_req && !dataGrant;
        end
        anyGrant    = instGrant || dataGrant;
        respOwner_d = dataGrant ? OWN_DATA : OWN_INST;
    end

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!inst_req || instGrant) begin
            starveCnt_d = '0;
        end else if (dataGrant && (starveCnt_q != CNT_MAX)) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end

    sram_arbiter_dfflr #(.DW(CW)) uStarveCnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .lden_i (1'b1),
        .dnxt_i (starveCnt_d),
        .qout_o (starveCnt_q)
    );

    sram_arbiter_dfflr #(.DW(1)) uRespVld (
        .clk_i  (clk),
        .rst_ni (reset),
        .lden_i (1'b1),
        .dnxt_i (anyGrant),
        .qout_o (respVld_q)
    );

    sram_arbiter_dfflr #(.DW(1)) uRespOwner (
        .clk_i  (clk),
        .rst_ni (reset),
        .lden_i (anyGrant),
        .dnxt_i (respOwner_d),
        .qout_o (respOwner_q)
    );

    sram_arbiter_dfflr #(.DW(1)) uRespWr (
        .clk_i  (clk),
        .rst_ni (reset),
        .lden_i (anyGrant),
        .dnxt_i (dataGrant && data_wr),
        .qout_o (respWr_q)
    );

    always_comb begin
        inst_addr_ok = instGrant;
        data_addr_ok = dataGrant;
        sram_en      = anyGrant;
        sram_wen     = wenFor(dataGrant && data_wr, data_wstrb);
        sram_addr    = '0;
        sram_wdata   = '0;
        if (dataGrant) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (instGrant) begin
            sram_addr  = inst_addr;
        end
    end

    // Response side: the SRAM word arrives one cycle after issue and goes to the owner only.
    always_comb begin
        inst_data_ok = respVld_q && (respOwner_q == OWN_INST);
        data_data_ok = respVld_q && (respOwner_q == OWN_DATA);
        inst_rdata   = inst_data_ok ? sram_rdata : '0;
        data_rdata   = (data_data_ok && !respWr_q) ? sram_rdata : '0;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive data grants while an instruction request waits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have inst_req (input, 1), inst_addr (input, AW), inst_addr_ok (output, 1), inst_data_ok (output, 1) and inst_rdata (output, DW) forming the fetch requester port.
REQ-007 SHALL have data_req (input, 1), data_wr (input, 1), data_wstrb (input, 4), data_addr (input, AW), data_wdata (input, DW), data_addr_ok (output, 1), data_data_ok (output, 1) and data_rdata (output, DW) forming the load/store requester port.
REQ-008 SHALL have sram_en (output, 1), sram_wen (output, 4), sram_addr (output, AW), sram_wdata (output, DW) and sram_rdata (input, DW) forming the single-port synchronous SRAM port, with 1-cycle read latency.

Function
REQ-009 SHALL grant at most one requester per cycle; a grant is signalled by a combinational addr_ok in the same cycle as the req.
REQ-010 SHALL grant data over inst, except when the starvation counter equals STARVE_MAX and inst_req=1, in which case it SHALL grant inst.
REQ-011 SHALL increment the starvation counter, saturating at STARVE_MAX, on every cycle with a data grant while inst_req=1.
REQ-012 SHALL clear the starvation counter on an inst grant, or on any cycle with inst_req=0.
REQ-013 SHALL drive sram_en=1 only in a granted cycle, with sram_addr and sram_wdata taken from the granted requester.
REQ-014 SHALL drive sram_wen=data_wstrb on a data write grant, and 4'b0 otherwise (inst grants and reads).
REQ-015 SHALL register response state (resp_vld, resp_owner, resp_wr) on each grant, so responses follow issue with 1-cycle latency.
REQ-016 SHALL assert the owner's data_ok exactly one cycle after its grant; for reads, the owner's rdata SHALL equal sram_rdata in that cycle.
REQ-017 SHALL assert data_data_ok for a write grant, with data_rdata=0.
REQ-018 SHALL hold the non-owner's rdata at 0, and SHALL never assert both data_ok outputs in the same cycle.
REQ-019 SHALL sustain back-to-back grants every cycle; issue and response of consecutive transactions overlap without bubbles.
REQ-020 SHALL handle data_wr=1 with data_wstrb=0 as a full handshake: sram_en=1, sram_wen=0, then data_ok.
REQ-021 SHALL leave all sram_* outputs at 0 and grant nothing on cycles with no requests.
REQ-022 SHALL accept no backpressure on data_ok; requesters always accept responses.

Reset
REQ-023 SHALL, while reset=0, drive all addr_ok, data_ok, rdata and sram_* outputs to 0, clear resp_vld and set the starvation counter to 0.
REQ-024 SHALL drop any pending response on reset assertion mid-transaction; that response SHALL never be signalled.
REQ-025 SHALL permit a grant in the first clock edge after reset deasserts.

Structure
REQ-026 SHALL take owner encoding constants (OWN_INST=0, OWN_DATA=1) and the SRAM read latency constant from the shared cpu.vh header.
REQ-027 SHALL implement response and counter registers with the codebase's sirv_gnrl_dfflr-style flop instances, adapted for async active-low reset.
REQ-028 SHALL contain no sub-module beyond flop instances; arbitration logic stays flat.

Verification
REQ-029 SHALL verify simultaneous access: inst_req=1 and data_req=1 (read, 0x100) in the same cycle -> data_addr_ok=1, inst_addr_ok=0; next cycle data_data_ok=1 with data_rdata equal to the preloaded mem[0x100].
REQ-030 SHALL verify starvation: data_req held for 6 cycles with inst_req held -> the 5th cycle grants inst (inst_addr_ok=1), and the counter returns to 0.
REQ-031 SHALL verify write strobes: data write to 0x20, wstrb=4'b0011, wdata=0xAABBCCDD, over 0x11223344 -> sram_wen=0011; a later read returns 0x1122CCDD.
REQ-032 SHALL verify pipelining: inst reads to 0x0, 0x4, 0x8 on consecutive cycles -> inst_data_ok high for 3 consecutive cycles, with rdata in order.
REQ-033 SHALL verify reset mid-operation: reset=0 in the cycle after a data read grant -> data_data_ok never asserted; all outputs 0 until release.
REQ-034 SHALL verify the zero-strobe write: data write with wstrb=0 -> sram_en=1, sram_wen=0, data_data_ok the next cycle, memory unchanged.
